// File: rtl/mcu_pkg.sv
// Shared MCU definitions: result-reader FSM encoding and its default frame geometry.
package mcu_pkg;

  localparam int unsigned DMEM_RESULT_BASE_IDX = 32;
  localparam int unsigned DMEM_RESULT_COUNT    = 16;

  typedef enum logic [1:0] {
    RDR_IDLE  = 2'd0,
    RDR_FETCH = 2'd1,
    RDR_SEND  = 2'd2,
    RDR_FIN   = 2'd3
  } rdr_state_t;

endpackage

// File: rtl/dmem_result_reader.sv
// Drains a frame of 16-bit result words from data memory into a valid/ready stream,
// keeping a running modulo-2^16 checksum of the accepted words.
module dmem_result_reader
  import mcu_pkg::*;
#(
  parameter int unsigned BASE_IDX = DMEM_RESULT_BASE_IDX,
  parameter int unsigned COUNT    = DMEM_RESULT_COUNT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [31:0] ram_addr,
  input  logic [31:0] ram_rd,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [15:0] m_data,
  output logic [3:0]  m_index,
  output logic        m_last,
  output logic        busy,
  output logic        done,
  output logic [15:0] checksum
);

  localparam logic [3:0]  LAST_IDX   = 4'(COUNT - 1);
  localparam logic [5:0]  BASE_IDX6  = 6'(BASE_IDX);
  localparam logic [31:0] RESET_ADDR = {25'd0, BASE_IDX6, 1'b0};

  rdr_state_t  state_q, state_d;
  logic [3:0]  index_q;
  logic [31:0] addr_q;
  logic [5:0]  word_idx;
  logic [31:0] fetch_addr;
  logic        is_last;
  logic        unused_rd_hi;

  // Word index wraps inside the 64-word window addressable on bits [6:1].
  assign word_idx     = BASE_IDX6 + {2'b00, index_q};
  assign fetch_addr   = {25'd0, word_idx, 1'b0};
  assign is_last      = (index_q == LAST_IDX);
  assign unused_rd_hi = ^ram_rd[31:16];

  // NOTE: state and datapath registers use non-blocking assignments so every
  // flop samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RDR_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RDR_IDLE:  if (start) state_d = RDR_FETCH;
      RDR_FETCH: state_d = RDR_SEND;
      RDR_SEND:  if (m_ready) state_d = is_last ? RDR_FIN : RDR_FETCH;
      RDR_FIN:   state_d = RDR_IDLE;
      default:   state_d = RDR_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      index_q  <= '0;
      m_data   <= '0;
      checksum <= '0;
      addr_q   <= RESET_ADDR;
    end else begin
      unique case (state_q)
        RDR_IDLE: begin
          if (start) begin
            index_q  <= '0;
            checksum <= '0;
          end
        end
        RDR_FETCH: begin
          m_data <= ram_rd[15:0];
          addr_q <= fetch_addr;
        end
        RDR_SEND: begin
          if (m_ready) begin
            checksum <= checksum + m_data;
            if (!is_last) index_q <= index_q + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs decode the registered state only; m_ready never reaches m_valid.
  assign ram_addr = (state_q == RDR_FETCH) ? fetch_addr : addr_q;
  assign m_valid  = (state_q == RDR_SEND);
  assign m_last   = (state_q == RDR_SEND) && is_last;
  assign m_index  = index_q;
  assign busy     = (state_q != RDR_IDLE);
  assign done     = (state_q == RDR_FIN);

endmodule

// File: tb/tb_dmem_result_reader.sv
// Three reader instances (32/16, 32/2, 40/8) checked every cycle against a
// transaction-timing model, plus directed literal checks of frame totals.
module tb_dmem_result_reader;

  localparam int N = 3;

  function automatic int cfg_base(input int i);
    return (i == 2) ? 40 : 32;
  endfunction

  function automatic int cfg_count(input int i);
    case (i)
      0:       return 16;
      1:       return 2;
      default: return 8;
    endcase
  endfunction

  function automatic logic [31:0] exp_addr(input int i, input int k);
    return 32'(((cfg_base(i) + k) % 64) * 2);
  endfunction

  logic        clk = 1'b0;
  logic        rst_n   [N];
  logic        start   [N];
  logic        m_ready [N];
  logic [31:0] ram_addr[N];
  logic [31:0] ram_rd  [N];
  logic        m_valid [N];
  logic [15:0] m_data  [N];
  logic [3:0]  m_index [N];
  logic        m_last  [N];
  logic        busy    [N];
  logic        done    [N];
  logic [15:0] checksum[N];
  logic [15:0] mem     [N][64];

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    dmem_result_reader #(
      .BASE_IDX(cfg_base(g)),
      .COUNT   (cfg_count(g))
    ) u_dut (
      .clk     (clk),
      .rst_n   (rst_n[g]),
      .start   (start[g]),
      .ram_addr(ram_addr[g]),
      .ram_rd  (ram_rd[g]),
      .m_valid (m_valid[g]),
      .m_ready (m_ready[g]),
      .m_data  (m_data[g]),
      .m_index (m_index[g]),
      .m_last  (m_last[g]),
      .busy    (busy[g]),
      .done    (done[g]),
      .checksum(checksum[g])
    );
    assign ram_rd[g] = {16'hA5A5, mem[g][ram_addr[g][6:1]]};
  end

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Model: a frame is a sequence of words; each word is presented one cycle
  // after its fetch cycle, the frame ends with one done cycle.
  bit          mdl_active[N];
  bit          mdl_fin   [N];
  bit          mdl_fetch [N];
  int          mdl_k     [N];
  logic [15:0] mdl_sum   [N];
  logic [31:0] mdl_addr  [N];

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (!rst_n[i]) begin
        mdl_active[i] <= 1'b0;
        mdl_fin[i]    <= 1'b0;
        mdl_fetch[i]  <= 1'b0;
        mdl_k[i]      <= 0;
        mdl_sum[i]    <= '0;
        mdl_addr[i]   <= 32'(cfg_base(i) * 2);
      end else if (!mdl_active[i]) begin
        if (start[i]) begin
          mdl_active[i] <= 1'b1;
          mdl_fetch[i]  <= 1'b1;
          mdl_k[i]      <= 0;
          mdl_sum[i]    <= '0;
        end
      end else if (mdl_fin[i]) begin
        mdl_active[i] <= 1'b0;
        mdl_fin[i]    <= 1'b0;
      end else if (mdl_fetch[i]) begin
        mdl_addr[i]  <= exp_addr(i, mdl_k[i]);
        mdl_fetch[i] <= 1'b0;
      end else if (m_ready[i]) begin
        mdl_sum[i] <= mdl_sum[i] + mem[i][(cfg_base(i) + mdl_k[i]) % 64];
        if (mdl_k[i] == cfg_count(i) - 1) begin
          mdl_fin[i] <= 1'b1;
        end else begin
          mdl_k[i]     <= mdl_k[i] + 1;
          mdl_fetch[i] <= 1'b1;
        end
      end
    end
  end

  int          done_obs[N] = '{0, 0, 0};
  int          last_cnt0   = 0;
  logic [15:0] last_data0  = '0;
  logic [31:0] last_addr2  = '0;
  logic [3:0]  last_idx2   = '0;

  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (!rst_n[i]) begin
        check($sformatf("rst_valid[%0d]", i), m_valid[i], 1'b0);
        check($sformatf("rst_busy[%0d]", i), busy[i], 1'b0);
        check($sformatf("rst_done[%0d]", i), done[i], 1'b0);
        check($sformatf("rst_sum[%0d]", i), checksum[i], 16'h0);
        check($sformatf("rst_addr[%0d]", i), ram_addr[i], 32'(cfg_base(i) * 2));
      end else begin
        logic exp_valid;
        exp_valid = mdl_active[i] && !mdl_fin[i] && !mdl_fetch[i];
        check($sformatf("m_valid[%0d]", i), m_valid[i], exp_valid);
        check($sformatf("busy[%0d]", i), busy[i], mdl_active[i]);
        check($sformatf("done[%0d]", i), done[i], mdl_fin[i]);
        check($sformatf("checksum[%0d]", i), checksum[i], mdl_sum[i]);
        check($sformatf("m_last[%0d]", i), m_last[i],
              exp_valid && (mdl_k[i] == cfg_count(i) - 1));
        check($sformatf("ram_addr[%0d]", i), ram_addr[i],
              (mdl_active[i] && mdl_fetch[i]) ? exp_addr(i, mdl_k[i]) : mdl_addr[i]);
        if (exp_valid) begin
          check($sformatf("m_data[%0d]", i), m_data[i],
                mem[i][(cfg_base(i) + mdl_k[i]) % 64]);
          check($sformatf("m_index[%0d]", i), m_index[i], 32'(mdl_k[i]));
        end
        if (done[i]) done_obs[i]++;
      end
    end
    if (rst_n[0] && m_valid[0] && m_last[0]) begin
      last_cnt0++;
      last_data0 = m_data[0];
    end
    if (rst_n[2] && m_valid[2] && m_last[2]) begin
      last_addr2 = ram_addr[2];
      last_idx2  = m_index[2];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_all_idle(input string name);
    int cyc;
    cyc = 0;
    for (int i = 0; i < N; i++) begin
      m_ready[i] = 1'b1;
      start[i]   = 1'b0;
    end
    while ((busy[0] || busy[1] || busy[2]) && cyc < 200) begin
      tick();
      cyc++;
    end
    check(name, {busy[0], busy[1], busy[2]}, 3'b000);
  endtask

  initial begin
    int          cyc;
    int          d0;
    logic [15:0] sum0;

    for (int i = 0; i < N; i++) begin
      rst_n[i]   = 1'b0;
      start[i]   = 1'b0;
      m_ready[i] = 1'b1;
      for (int a = 0; a < 64; a++) mem[i][a] = 16'($urandom);
    end
    for (int w = 0; w < 16; w++) mem[0][32 + w] = 16'(w + 1);
    mem[1][32] = 16'hFFFF;
    mem[1][33] = 16'hFFFF;

    repeat (3) tick();
    for (int i = 0; i < N; i++) begin
      check($sformatf("reset_m_data[%0d]", i), m_data[i], 16'h0);
      check($sformatf("reset_m_index[%0d]", i), m_index[i], 4'h0);
      check($sformatf("reset_m_last[%0d]", i), m_last[i], 1'b0);
    end
    check("reset_addr0_lit", ram_addr[0], 32'h40);
    check("reset_addr2_lit", ram_addr[2], 32'h50);
    for (int i = 0; i < N; i++) rst_n[i] = 1'b1;
    tick();

    // Directed frame on all instances with m_ready held high.
    for (int i = 0; i < N; i++) start[i] = 1'b1;
    tick();
    for (int i = 0; i < N; i++) start[i] = 1'b0;
    check("first_fetch_addr0", ram_addr[0], 32'h40);
    check("first_fetch_addr2", ram_addr[2], 32'h50);
    cyc = 1;
    while (!done[0] && cyc < 200) begin
      tick();
      cyc++;
    end
    check("done_latency0", 32'(cyc), 32'd33);
    check("checksum0_lit", checksum[0], 16'h0088);
    check("checksum1_wrap", checksum[1], 16'hFFFE);
    check("done_count1", 32'(done_obs[1]), 32'd1);
    check("last_count0", 32'(last_cnt0), 32'd1);
    check("last_data0", last_data0, 16'h0010);
    check("last_addr2", last_addr2, 32'h5E);
    check("last_index2", last_idx2, 4'd7);
    wait_all_idle("idle_after_directed");

    // Randomised frames: random back-pressure, a 3-cycle stall and a re-start.
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < N; i++)
        for (int a = 0; a < 64; a++) mem[i][a] = 16'($urandom);
      sum0 = '0;
      for (int w = 0; w < 16; w++) sum0 = sum0 + mem[0][32 + w];
      d0 = done_obs[0];
      for (int i = 0; i < N; i++) start[i] = 1'b1;
      tick();
      cyc = 0;
      while (busy[0] && cyc < 400) begin
        for (int i = 0; i < N; i++) begin
          start[i]   = (r == 0 && cyc == 10);
          m_ready[i] = (r == 0 && cyc >= 6 && cyc < 9) ? 1'b0
                                                       : ($urandom_range(0, 3) != 0);
        end
        tick();
        cyc++;
      end
      check($sformatf("rand_frame_end[%0d]", r), busy[0], 1'b0);
      wait_all_idle($sformatf("rand_idle[%0d]", r));
      check($sformatf("rand_sum0[%0d]", r), checksum[0], sum0);
      check($sformatf("rand_done0[%0d]", r), 32'(done_obs[0] - d0), 32'd1);
    end

    // Reset while word 5 is on the bus abandons the frame.
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    cyc = 0;
    while (!(m_valid[0] && m_index[0] == 4'd5) && cyc < 40) begin
      tick();
      cyc++;
    end
    check("word5_reached", m_index[0], 4'd5);
    d0       = done_obs[0];
    rst_n[0] = 1'b0;
    #1;
    check("midrst_valid", m_valid[0], 1'b0);
    check("midrst_data", m_data[0], 16'h0);
    check("midrst_index", m_index[0], 4'h0);
    check("midrst_busy", busy[0], 1'b0);
    check("midrst_sum", checksum[0], 16'h0);
    check("midrst_addr", ram_addr[0], 32'h40);
    repeat (2) tick();
    rst_n[0] = 1'b1;
    repeat (10) tick();
    check("no_done_after_rst", 32'(done_obs[0] - d0), 32'd0);
    check("idle_after_rst", busy[0], 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
